// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access : memory-access (MA) pipeline stage.
//
// Sits behind the EX/MA register. Issues loads/stores on a 64-bit valid/ready
// request channel, waits for the one-cycle response pulse, aligns and extends
// load data, and registers the writeback payload into the MA/WB register.
// stall_req freezes upstream (including EX/MA) while a transaction is open, so
// EX/MA advances on the same edge the response is captured.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   clear             flush MA/WB to a bubble; an open transaction is drained
//   pc_in, rd_in      PC / destination register from EX/MA
//   result_in         ALU result, byte address for memory ops
//   data2_in          store data
//   ld_op, st_op      load / store (both set is treated as a store)
//   mem_size          0=B 1=H 2=W 3=D
//   mem_unsigned      zero-extend load data
//   req_*             bus request channel (valid/ready)
//   rsp_valid/rdata   bus response, one-cycle pulse, full doubleword
//   stall_req         freeze upstream stages
//   misalign_en/addr  misaligned-access trap pulse and faulting address
//   pc_out, rd_out, wb_data_out, valid_out   MA/WB register
// -----------------------------------------------------------------------------
module mem_access #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic [XLEN-1:0] pc_in,
   input  logic [4:0]      rd_in,
   input  logic [XLEN-1:0] result_in,
   input  logic [XLEN-1:0] data2_in,
   input  logic            ld_op,
   input  logic            st_op,
   input  logic [1:0]      mem_size,
   input  logic            mem_unsigned,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   output logic            req_wr,
   output logic [XLEN-1:0] req_wdata,
   output logic [7:0]      req_wmask,
   input  logic            rsp_valid,
   input  logic [XLEN-1:0] rsp_rdata,
   output logic            stall_req,
   output logic            misalign_en,
   output logic [XLEN-1:0] misalign_addr,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rd_out,
   output logic [XLEN-1:0] wb_data_out,
   output logic            valid_out
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

   state_t state_q, state_d;
   logic   kill_q, kill_d;   // clear seen before the request was accepted

   logic       mem_op, misal, issue;
   logic [2:0] off;
   logic [7:0] mask_base, wmask_c;
   logic [XLEN-1:0] wdata_c;

   // Request fields captured at issue so they stay put while REQ waits on
   // ready and so load alignment is known when the response arrives.
   logic [XLEN-1:0] op_addr_q, op_wdata_q, op_pc_q;
   logic [7:0]      op_wmask_q;
   logic [4:0]      op_rd_q;
   logic [1:0]      op_size_q;
   logic            op_wr_q, op_uns_q;

   logic [XLEN-1:0] wb_pc_q, wb_data_q;
   logic [4:0]      wb_rd_q;
   logic            wb_vld_q;

   logic [XLEN-1:0] ld_sh, ld_data;

   assign mem_op = ld_op | st_op;
   assign off    = result_in[2:0];

   always_comb begin
      misal     = 1'b0;
      mask_base = 8'h01;
      case (mem_size)
         2'd0: begin misal = 1'b0;        mask_base = 8'h01; end
         2'd1: begin misal = off[0];      mask_base = 8'h03; end
         2'd2: begin misal = |off[1:0];   mask_base = 8'h0F; end
         default: begin misal = |off;     mask_base = 8'hFF; end
      endcase
   end

   assign wmask_c = mask_base << off;
   assign wdata_c = data2_in << {off, 3'b000};
   assign issue   = (state_q == IDLE) & mem_op & ~misal;

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      kill_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               if (req_ready) state_d = clear ? DRAIN : WAIT;
               else begin
                  state_d = REQ;
                  kill_d  = clear;
               end
            end
         end
         REQ: begin
            kill_d = kill_q | clear;
            if (req_ready) state_d = (kill_q | clear) ? DRAIN : WAIT;
         end
         WAIT: begin
            // A response in the clear cycle still closes the transaction;
            // the clear itself bubbles MA/WB.
            if (rsp_valid)  state_d = IDLE;
            else if (clear) state_d = DRAIN;
         end
         DRAIN: begin
            if (rsp_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         op_pc_q    <= '0;
         op_wmask_q <= '0;
         op_rd_q    <= '0;
         op_size_q  <= '0;
         op_wr_q    <= 1'b0;
         op_uns_q   <= 1'b0;
      end else if (issue) begin
         op_addr_q  <= result_in;
         op_wdata_q <= wdata_c;
         op_pc_q    <= pc_in;
         op_wmask_q <= wmask_c;
         op_rd_q    <= rd_in;
         op_size_q  <= mem_size;
         op_wr_q    <= st_op;
         op_uns_q   <= mem_unsigned;
      end
   end

   // ---------------- bus / control outputs ----------------
   always_comb begin
      if (state_q == IDLE) begin
         req_addr  = {result_in[XLEN-1:3], 3'b000};
         req_wr    = st_op;
         req_wdata = wdata_c;
         req_wmask = wmask_c;
      end else begin
         req_addr  = {op_addr_q[XLEN-1:3], 3'b000};
         req_wr    = op_wr_q;
         req_wdata = op_wdata_q;
         req_wmask = op_wmask_q;
      end
   end

   assign req_valid     = rst_n & (issue | (state_q == REQ));
   assign stall_req     = rst_n & (issue | (state_q == REQ) |
                          (((state_q == WAIT) | (state_q == DRAIN)) & ~rsp_valid));
   assign misalign_en   = rst_n & (state_q == IDLE) & mem_op & misal;
   assign misalign_addr = result_in;

   // ---------------- load alignment / extension ----------------
   assign ld_sh = rsp_rdata >> {op_addr_q[2:0], 3'b000};

   always_comb begin
      case (op_size_q)
         2'd0:    ld_data = op_uns_q ? {56'd0, ld_sh[7:0]}  : {{56{ld_sh[7]}},  ld_sh[7:0]};
         2'd1:    ld_data = op_uns_q ? {48'd0, ld_sh[15:0]} : {{48{ld_sh[15]}}, ld_sh[15:0]};
         2'd2:    ld_data = op_uns_q ? {32'd0, ld_sh[31:0]} : {{32{ld_sh[31]}}, ld_sh[31:0]};
         default: ld_data = ld_sh;
      endcase
   end

   // ---------------- MA/WB register ----------------
   // Stalled, misaligned and drained cycles write a bubble so writeback sees
   // each instruction exactly once.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_pc_q   <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         wb_vld_q  <= 1'b0;
      end else if (clear) begin
         wb_rd_q  <= '0;
         wb_vld_q <= 1'b0;
      end else if (state_q == IDLE && !mem_op) begin
         wb_pc_q   <= pc_in;
         wb_rd_q   <= rd_in;
         wb_data_q <= result_in;
         wb_vld_q  <= 1'b1;
      end else if (state_q == WAIT && rsp_valid) begin
         wb_pc_q   <= op_pc_q;
         wb_rd_q   <= op_wr_q ? 5'd0 : op_rd_q;
         wb_data_q <= op_wr_q ? op_addr_q : ld_data;
         wb_vld_q  <= 1'b1;
      end else begin
         wb_rd_q  <= '0;
         wb_vld_q <= 1'b0;
      end
   end

   assign pc_out      = wb_pc_q;
   assign rd_out      = wb_rd_q;
   assign wb_data_out = wb_data_q;
   assign valid_out   = wb_vld_q;

endmodule
